// File: rtl/pixel_stream_packer.sv
// Packs PACK consecutive pixels into one word, flushing partial words at line/frame ends,
// and queues the words in a show-ahead FIFO with a sticky overflow flag.
module pixel_stream_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int PACK       = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            pixel_in,
  input  logic                             pixel_valid,
  input  logic                             line_end,
  input  logic                             frame_end,
  output logic [PACK*DATA_WIDTH-1:0]       word_out,
  output logic [PACK-1:0]                  word_keep,
  output logic                             word_last_line,
  output logic                             word_last_frame,
  output logic                             word_valid,
  input  logic                             word_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level,
  output logic                             overflow,
  input  logic                             ovf_clr
);

  localparam int WW  = PACK * DATA_WIDTH;
  localparam int LNW = $clog2(PACK);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LVW = $clog2(FIFO_DEPTH + 1);

  logic [LNW-1:0]  lane_q, lane_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic [WW-1:0]   word_s;
  logic [PACK-1:0] keep_s;
  logic            complete_s;

  logic [WW-1:0]   data_mem_q [FIFO_DEPTH];
  logic [PACK-1:0] keep_mem_q [FIFO_DEPTH];
  logic            ll_mem_q   [FIFO_DEPTH];
  logic            lf_mem_q   [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVW-1:0]  level_q, level_d;
  logic            ovf_q, ovf_d;
  logic            full_s, pop_s, push_s, drop_s;

  // The accumulator keeps lanes above the current one at zero, so inserting the
  // incoming pixel yields the completed word directly.
  always_comb begin
    word_s     = acc_q;
    keep_s     = '0;
    word_s[int'(lane_q)*DATA_WIDTH +: DATA_WIDTH] = pixel_in;
    for (int i = 0; i < PACK; i++) begin
      keep_s[i] = (i <= int'(lane_q));
    end
    complete_s = pixel_valid & ((lane_q == LNW'(PACK - 1)) | line_end | frame_end);
    lane_d     = lane_q;
    acc_d      = acc_q;
    if (pixel_valid) begin
      if (complete_s) begin
        lane_d = '0;
        acc_d  = '0;
      end else begin
        lane_d = lane_q + LNW'(1);
        acc_d  = word_s;
      end
    end else begin
      lane_d = lane_q;
      acc_d  = acc_q;
    end
  end

  // FIFO control: a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    full_s   = (level_q == LVW'(FIFO_DEPTH));
    pop_s    = (level_q != LVW'(0)) & word_ready;
    push_s   = complete_s & (~full_s | pop_s);
    drop_s   = complete_s & full_s & ~pop_s;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVW'(1);
      2'b01:   level_d = level_q - LVW'(1);
      default: level_d = level_q;
    endcase
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Pack stage and FIFO bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      lane_q   <= lane_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage is reset so the head fields read as zero, never X, while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        keep_mem_q[i] <= '0;
        ll_mem_q[i]   <= 1'b0;
        lf_mem_q[i]   <= 1'b0;
      end
    end else if (push_s) begin
      data_mem_q[wr_ptr_q] <= word_s;
      keep_mem_q[wr_ptr_q] <= keep_s;
      ll_mem_q[wr_ptr_q]   <= line_end | frame_end;
      lf_mem_q[wr_ptr_q]   <= frame_end;
    end
  end

  assign word_out        = data_mem_q[rd_ptr_q];
  assign word_keep       = keep_mem_q[rd_ptr_q];
  assign word_last_line  = ll_mem_q[rd_ptr_q];
  assign word_last_frame = lf_mem_q[rd_ptr_q];
  assign word_valid      = (level_q != LVW'(0));
  assign fifo_level      = level_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Randomized and directed checks of pixel_stream_packer against a queue-based word model.
module tb_pixel_stream_packer;
  localparam int DW = 8;
  localparam int PK = 4;
  localparam int FD = 16;

  typedef struct packed {
    logic [PK*DW-1:0] data;
    logic [PK-1:0]    keep;
    logic             ll;
    logic             lf;
  } word_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] pixel_in = '0;
  logic pixel_valid = 1'b0, line_end = 1'b0, frame_end = 1'b0;
  logic word_ready = 1'b0, ovf_clr = 1'b0;
  logic [PK*DW-1:0] word_out;
  logic [PK-1:0] word_keep;
  logic word_last_line, word_last_frame, word_valid, overflow;
  logic [$clog2(FD+1)-1:0] fifo_level;

  int checks = 0, errors = 0;
  int pend[$];
  word_t mq[$];
  logic m_ovf = 1'b0;

  pixel_stream_packer #(.DATA_WIDTH(DW), .PACK(PK), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
    .line_end(line_end), .frame_end(frame_end), .word_out(word_out), .word_keep(word_keep),
    .word_last_line(word_last_line), .word_last_frame(word_last_frame),
    .word_valid(word_valid), .word_ready(word_ready), .fifo_level(fifo_level),
    .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    pend.delete();
    mq.delete();
    m_ovf = 1'b0;
  endtask

  // Drives one cycle and advances the model; called at posedge+1, returns at posedge+1.
  task automatic drive(input logic pv, input logic [DW-1:0] px, input logic le,
                       input logic fe, input logic rdy, input logic clr);
    word_t w;
    bit do_pop, done, drop;
    pixel_valid = pv; pixel_in = px; line_end = le; frame_end = fe;
    word_ready = rdy; ovf_clr = clr;
    do_pop = (mq.size() != 0) && rdy;
    done = 1'b0; drop = 1'b0;
    w = '0;
    if (pv) begin
      pend.push_back(int'(px));
      if (pend.size() == PK || le || fe) begin
        done = 1'b1;
        for (int i = 0; i < pend.size(); i++) begin
          w.data[i*DW +: DW] = pend[i][DW-1:0];
          w.keep[i] = 1'b1;
        end
        w.ll = le | fe;
        w.lf = fe;
        pend.delete();
      end
    end
    @(posedge clk);
    #1;
    if (do_pop) void'(mq.pop_front());
    if (done) begin
      if (mq.size() < FD) mq.push_back(w);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    pixel_valid = 1'b0; line_end = 1'b0; frame_end = 1'b0; ovf_clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({word_out, word_keep, word_last_line, word_last_frame, word_valid, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h keep=%h v=%b lvl=%0d ovf=%b, want all 0",
               word_out, word_keep, word_valid, fifo_level, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (word_valid !== 1'b0 || fifo_level !== 0) begin
      errors++;
      $display("FAIL reset_release: got v=%b lvl=%0d, want 0 0", word_valid, fifo_level);
    end
  endtask

  task automatic test_aligned_line();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(i + 1), i == 7, 1'b0, 1'b1, 1'b0);
      if (i == 2) begin
        checks++;
        if (word_valid !== 1'b0) begin
          errors++; $display("FAIL aligned_latency: got v=%b, want 0", word_valid);
        end
      end
      if (i == 3 || i == 7) begin
        checks++;
        if (word_valid !== 1'b1 || word_out !== (i == 3 ? 32'h04030201 : 32'h08070605) ||
            word_keep !== 4'hF || word_last_line !== (i == 7) || word_last_frame !== 1'b0) begin
          errors++;
          $display("FAIL aligned_word%0d: got v=%b out=%h keep=%h ll=%b lf=%b", i / 4,
                   word_valid, word_out, word_keep, word_last_line, word_last_frame);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (word_valid !== 1'b0) begin
      errors++; $display("FAIL aligned_drain: got v=%b, want 0", word_valid);
    end
  endtask

  task automatic test_partial_flush();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, DW'(8'h10 + i), i == 5, i == 5, 1'b1, 1'b0);
      if (i == 3 || i == 5) begin
        checks++;
        if (word_out !== (i == 3 ? 32'h13121110 : 32'h00001514) ||
            word_keep !== (i == 3 ? 4'hF : 4'h3) || word_last_line !== (i == 5) ||
            word_last_frame !== (i == 5) || word_valid !== 1'b1) begin
          errors++;
          $display("FAIL partial_word%0d: got v=%b out=%h keep=%h ll=%b lf=%b", i / 4,
                   word_valid, word_out, word_keep, word_last_line, word_last_frame);
        end
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 68; i++) begin
      drive(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0, 1'b0);
      if (i == 63) begin
        checks++;
        if (fifo_level !== 16 || overflow !== 1'b0) begin
          errors++; $display("FAIL ovf_fill16: got lvl=%0d ovf=%b, want 16 0", fifo_level, overflow);
        end
      end
    end
    checks++;
    if (fifo_level !== 16 || overflow !== 1'b1 || mq.size() != 16) begin
      errors++; $display("FAIL ovf_17th: got lvl=%0d ovf=%b, want 16 1", fifo_level, overflow);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (word_valid !== 1'b1 || mq.size() == 0 || word_out !== mq[0].data ||
          word_out[7:0] !== DW'(8'h40 + 4 * k)) begin
        errors++; $display("FAIL ovf_drain%0d: got v=%b out=%h", k, word_valid, word_out);
      end
      drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (word_valid !== 1'b0 || fifo_level !== 0) begin
      errors++; $display("FAIL ovf_empty: got v=%b lvl=%0d, want 0 0", word_valid, fifo_level);
    end
  endtask

  task automatic test_full_pop();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_alone: got ovf=%b, want 0", overflow);
    end
    for (int i = 0; i < 68; i++) begin
      drive(1'b1, DW'(i), 1'b0, 1'b0, i == 67, 1'b0);
    end
    checks++;
    if (fifo_level !== 16 || overflow !== 1'b0 || word_out !== 32'h07060504) begin
      errors++;
      $display("FAIL full_pop: got lvl=%0d ovf=%b head=%h, want 16 0 07060504", fifo_level, overflow, word_out);
    end
  endtask

  task automatic test_ovf_clr_drop();
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(i), 1'b0, 1'b0, 1'b0, i == 3);
    checks++;
    if (overflow !== 1'b1 || fifo_level !== 16) begin
      errors++; $display("FAIL clr_vs_drop: got ovf=%b lvl=%0d, want 1 16", overflow, fifo_level);
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL clr_after_drop: got ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 8'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({word_out, word_keep, word_last_line, word_last_frame, word_valid, fifo_level, overflow} !== '0) begin
      errors++;
      $display("FAIL async_reset: got out=%h keep=%h v=%b lvl=%0d ovf=%b, want all 0",
               word_out, word_keep, word_valid, fifo_level, overflow);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hA0 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (word_valid !== 1'b1 || word_out !== 32'hA3A2A1A0 || word_keep !== 4'hF || fifo_level !== 1) begin
      errors++;
      $display("FAIL post_reset_word: got v=%b out=%h keep=%h lvl=%0d, want 1 a3a2a1a0 f 1",
               word_valid, word_out, word_keep, fifo_level);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 9) < 7, DW'($urandom_range(0, 255)), $urandom_range(0, 9) == 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, $urandom_range(0, 19) == 0);
      checks++;
      if (word_valid !== (mq.size() != 0) || fifo_level !== mq.size() || overflow !== m_ovf) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d: got v=%b lvl=%0d ovf=%b, want lvl=%0d ovf=%b",
                 c, word_valid, fifo_level, overflow, mq.size(), m_ovf);
      end
      if (mq.size() != 0) begin
        checks++;
        if (word_out !== mq[0].data || word_keep !== mq[0].keep ||
            word_last_line !== mq[0].ll || word_last_frame !== mq[0].lf) begin
          errors++;
          $display("FAIL rand_head c=%0d: got %h/%h/%b/%b, want %h/%h/%b/%b", c, word_out,
                   word_keep, word_last_line, word_last_frame, mq[0].data, mq[0].keep, mq[0].ll, mq[0].lf);
        end
      end
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_aligned_line();
    test_partial_flush();
    test_overflow();
    test_full_pop();
    test_ovf_clr_drop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Downstream stage of the Gaussian filter. Consumes the filter's output pixel stream (`pixel_out`, `pixel_valid_out`, `line_end_out`, `frame_end_out`), packs PACK consecutive pixels into one word, and flushes a partial word at each line end. Words carry line/frame markers and wait in a FIFO behind a valid/ready handshake toward the DMA/bus writer. The upstream side cannot be stalled, so the block absorbs bursts in the FIFO and flags any loss through a sticky overflow bit.

## Interface
- DATA_WIDTH, 8, pixel width; must match the filter's DATA_WIDTH
- PACK, 4, pixels per output word; legal range 2..8
- FIFO_DEPTH, 16, word entries; power of two, ≥ 2
- clk  in  1  single clock for the whole block
- rst_n  in  1  reset; asynchronous, active-low
- pixel_in  in  DATA_WIDTH  pixel, sampled when pixel_valid=1
- pixel_valid  in  1  pixel strobe; no backpressure exists upstream
- line_end  in  1  last pixel of a line; qualified by pixel_valid
- frame_end  in  1  last pixel of a frame; qualified by pixel_valid
- word_out  out  PACK*DATA_WIDTH  packed word; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- word_keep  out  PACK  lane-valid mask; bit i = lane i holds a pixel
- word_last_line  out  1  word closes a line
- word_last_frame  out  1  word closes a frame
- word_valid  out  1  FIFO head is valid
- word_ready  in  1  consumer accepts the word when word_valid & word_ready
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words currently stored
- overflow  out  1  sticky; at least one word was dropped
- ovf_clr  in  1  clears overflow

## Operation
- **Pack stage.**
  - Holds a lane counter `lane` (0..PACK-1) and a PACK-lane accumulator.
  - On each pixel_valid, pixel_in is written to lane `lane`.
  - The first pixel of a word goes in lane 0 (little-endian).
- **Word completion.** A word completes on a pixel_valid cycle when any of these is true: `lane == PACK-1`, line_end=1, or frame_end=1.
  - frame_end alone acts as an implied line end.
- **Completed word contents.**
  - Lanes 0..lane hold pixel data; the completing pixel is included.
  - Higher lanes are forced to 0.
  - word_keep has bits 0..lane set.
  - last_line = line_end | frame_end.
  - last_frame = frame_end.
  - `lane` returns to 0.
- If a word does not complete, `lane` increments.
- Cycles with pixel_valid=0 change nothing. line_end/frame_end are ignored while pixel_valid=0.
- **FIFO.** Show-ahead. The head drives word_out, word_keep, word_last_line and word_last_frame; word_valid = (level ≠ 0).
  - A pop occurs when word_valid & word_ready.
  - A push is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
- **Overflow.** A completed word that cannot be pushed is discarded whole and overflow is set.
  - The pack stage still resets `lane` to 0, so the next pixel starts a fresh word.
- **ovf_clr.** overflow clears on an ovf_clr cycle. If a drop happens in the same cycle, set wins.
- **Level.** fifo_level is incremented by each push and decremented by each pop; a simultaneous push and pop leaves it unchanged.
- Output fields are don't-care while word_valid=0, but they must not contain X after reset.

## Timing
- **Reset.** While rst_n=0, and immediately after its asynchronous assertion:
  - lane=0 and the accumulator is zeroed.
  - FIFO is empty, word_valid=0, fifo_level=0, overflow=0.
  - word_out, word_keep, word_last_line and word_last_frame are all 0.
- **Reset mid-word or mid-frame.** Partial data is lost; no word is emitted for it.
- **Latency.** The completing pixel is sampled at edge N; word_valid=1 and the word sits at the head from just after edge N. That is one cycle of latency into an empty FIFO.
- **Word stability.** While word_valid=1 and word_ready=0, the head word and all its fields stay stable.
- **Throughput.**
  - Sustained one pop per cycle is supported.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full.
- **Minimum frame.** A 1-pixel line (pixel_valid, line_end and frame_end all set) produces a single word with keep=...0001, last_line=1, last_frame=1.
- **overflow timing.** overflow rises the cycle after the dropped push edge; it is registered.

## Test plan
- **Aligned line.** 8 pixels 0x01..0x08 with line_end on the 8th, word_ready=1, PACK=4 → two words: 0x04030201 keep=F last_line=0, then 0x08070605 keep=F last_line=1. Each word_valid appears 1 cycle after its 4th/8th pixel.
- **Partial flush.** 6 pixels 0x10..0x15, line_end+frame_end on the 6th → words 0x13121110 keep=F, then 0x00001514 keep=3 with last_line=1 and last_frame=1.
- **Backpressure and overflow.** word_ready=0, push 17 full words (68 pixels), FIFO_DEPTH=16 → fifo_level saturates at 16 and overflow=1 after the 17th word. Then raise word_ready: exactly 16 words are drained, matching the first 16 pushed in order.
- **Full + simultaneous pop.** With the FIFO full and word_ready=1, a word completes → push accepted, level stays 16, no overflow.
- **ovf_clr vs drop.** Assert ovf_clr in the same cycle as a drop → overflow stays 1. Assert ovf_clr alone → overflow=0 next cycle.
- **Async reset mid-word.** Push 2 pixels, pulse rst_n low between clock edges → all outputs are 0 immediately. The next 4 pixels after reset form one clean word starting at lane 0.
